// File: rtl/lstm_log_pkg.sv
// Shared types and counter widths for the frame logging arbiter.
//   state_e  : arbiter FSM states (IDLE between frames, XFER while a frame is open)
//   *_W      : widths of the word, idle, frame and drop counters
package lstm_log_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  localparam int WCNT_W  = 16;  // words accepted within the current frame
  localparam int IDLE_W  = 16;  // consecutive cycles without an accepted word
  localparam int FRAME_W = 32;  // completed frames, wrapping
  localparam int DROP_W  = 16;  // dropped strobes, saturating

endpackage

// File: rtl/frame_log_arbiter_rr_pick.sv
// Round-robin picker: selects the first requester at or after (last+1) mod N_SRC.
//   req   : per-source request vector
//   last  : index of the previously served source
//   grant : one-hot pick, all zero when nobody requests
//   index : binary index of the pick (0 when nobody requests)
module rr_pick #(
  parameter int N_SRC = 4
) (
  input  logic [N_SRC-1:0]         req,
  input  logic [$clog2(N_SRC)-1:0] last,
  output logic [N_SRC-1:0]         grant,
  output logic [$clog2(N_SRC)-1:0] index
);

  localparam int IDX_W = $clog2(N_SRC);

  logic [IDX_W-1:0] cand;
  logic             found;

  // Walk the sources starting just after the last winner; the first hit wins.
  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= N_SRC; i++) begin
      cand = IDX_W'((int'(last) + i) % N_SRC);
      if (!found && req[cand]) begin
        grant[cand] = 1'b1;
        index       = cand;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_log_arbiter.sv
// Frame logging arbiter: grants one source at a time for a LENGTH-word frame and
// forwards its samples to a single logger sink with one cycle of registered latency.
//   clk, rst           : clock and asynchronous active-high reset
//   src_req            : per-source frame request (level)
//   src_data/src_valid : per-source sample and strobe
//   src_grant          : one-hot grant, zero between frames
//   out_data/out_valid : forwarded sample and qualifier, out_src_id tags the source
//   out_last           : accompanies the final word of a frame
//   out_abort          : one-cycle pulse when a frame is abandoned on idle timeout
//   frame_cnt          : completed frames (wraps); drop_cnt : ungranted strobes (saturates)
module frame_log_arbiter
  import lstm_log_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int LENGTH  = 64,
  parameter int N_SRC   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_SRC-1:0]              src_req,
  input  logic [N_SRC-1:0][WIDTH-1:0]   src_data,
  input  logic [N_SRC-1:0]              src_valid,
  output logic [N_SRC-1:0]              src_grant,
  output logic signed [WIDTH-1:0]       out_data,
  output logic                          out_valid,
  output logic [$clog2(N_SRC)-1:0]      out_src_id,
  output logic                          out_last,
  output logic                          out_abort,
  output logic [FRAME_W-1:0]            frame_cnt,
  output logic [DROP_W-1:0]             drop_cnt
);

  localparam int IDX_W = $clog2(N_SRC);

  state_e                   state_q, state_d;
  logic [N_SRC-1:0]         grant_q, grant_d;
  logic [IDX_W-1:0]         gidx_q, gidx_d;
  logic [IDX_W-1:0]         last_grant_q, last_grant_d;
  logic [WCNT_W-1:0]        word_cnt_q, word_cnt_d;
  logic [IDLE_W-1:0]        idle_q, idle_d;
  logic signed [WIDTH-1:0]  out_data_q, out_data_d;
  logic [IDX_W-1:0]         out_src_id_q, out_src_id_d;
  logic                     out_valid_q, out_valid_d;
  logic                     out_last_q, out_last_d;
  logic                     out_abort_q, out_abort_d;
  logic [FRAME_W-1:0]       frame_cnt_q, frame_cnt_d;
  logic [DROP_W-1:0]        drop_cnt_q, drop_cnt_d;

  logic [N_SRC-1:0]         pick_grant;
  logic [IDX_W-1:0]         pick_idx;
  logic [N_SRC-1:0]         drop_vec;
  logic [DROP_W-1:0]        drop_pop;
  logic                     accept, frame_end, timeout;

  function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] a,
                                                input logic [DROP_W-1:0] b);
    logic [DROP_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[DROP_W] ? '1 : sum[DROP_W-1:0];
  endfunction

  rr_pick #(.N_SRC(N_SRC)) u_pick (
    .req   (src_req),
    .last  (last_grant_q),
    .grant (pick_grant),
    .index (pick_idx)
  );

  assign accept    = (state_q == XFER) && src_valid[gidx_q];
  assign frame_end = accept && (word_cnt_q == WCNT_W'(LENGTH - 1));
  // Fires on the cycle that would bring the idle count up to TIMEOUT.
  assign timeout   = (state_q == XFER) && !accept && (idle_q == IDLE_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      gidx_q       <= '0;
      last_grant_q <= IDX_W'(N_SRC - 1);
      word_cnt_q   <= '0;
      idle_q       <= '0;
      out_data_q   <= '0;
      out_src_id_q <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_abort_q  <= 1'b0;
      frame_cnt_q  <= '0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      gidx_q       <= gidx_d;
      last_grant_q <= last_grant_d;
      word_cnt_q   <= word_cnt_d;
      idle_q       <= idle_d;
      out_data_q   <= out_data_d;
      out_src_id_q <= out_src_id_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      out_abort_q  <= out_abort_d;
      frame_cnt_q  <= frame_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|src_req) state_d = XFER;
      XFER:    if (frame_end || timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_d      = grant_q;
    gidx_d       = gidx_q;
    last_grant_d = last_grant_q;
    word_cnt_d   = word_cnt_q;
    idle_d       = idle_q;
    out_data_d   = out_data_q;
    out_src_id_d = out_src_id_q;
    out_valid_d  = 1'b0;
    out_last_d   = 1'b0;
    out_abort_d  = 1'b0;
    frame_cnt_d  = frame_cnt_q;

    // Any strobe from a source that does not hold the grant is lost.
    drop_vec = src_valid & ~grant_q;
    drop_pop = '0;
    for (int i = 0; i < N_SRC; i++) drop_pop = drop_pop + DROP_W'(drop_vec[i]);
    drop_cnt_d = sat_add(drop_cnt_q, drop_pop);

    case (state_q)
      IDLE: begin
        if (|src_req) begin
          grant_d    = pick_grant;
          gidx_d     = pick_idx;
          word_cnt_d = '0;
          idle_d     = '0;
        end
      end
      XFER: begin
        if (accept) begin
          out_data_d   = $signed(src_data[gidx_q]);
          out_src_id_d = gidx_q;
          out_valid_d  = 1'b1;
          idle_d       = '0;
          if (frame_end) begin
            out_last_d   = 1'b1;
            frame_cnt_d  = frame_cnt_q + FRAME_W'(1);
            last_grant_d = gidx_q;
            grant_d      = '0;
            word_cnt_d   = '0;
          end else begin
            word_cnt_d = word_cnt_q + WCNT_W'(1);
          end
        end else if (timeout) begin
          out_abort_d  = 1'b1;
          last_grant_d = gidx_q;
          grant_d      = '0;
          word_cnt_d   = '0;
          idle_d       = '0;
        end else begin
          idle_d = idle_q + IDLE_W'(1);
        end
      end
      default: begin
        grant_d = '0;
      end
    endcase
  end

  assign src_grant  = grant_q;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign out_src_id = out_src_id_q;
  assign out_last   = out_last_q;
  assign out_abort  = out_abort_q;
  assign frame_cnt  = frame_cnt_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_frame_log_arbiter.sv
// Directed bench for frame_log_arbiter: single-source frame, round robin, drops,
// idle timeout, reset mid-frame and drop counter saturation.
module tb_frame_log_arbiter;

  logic              clk;
  logic              rst;
  logic [3:0]        src_req;
  logic [3:0][15:0]  src_data;
  logic [3:0]        src_valid;
  logic [3:0]        src_grant;
  logic signed [15:0] out_data;
  logic              out_valid;
  logic [1:0]        out_src_id;
  logic              out_last;
  logic              out_abort;
  logic [31:0]       frame_cnt;
  logic [15:0]       drop_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [15:0] wdata[$];
  logic [1:0]  wid[$];
  int          wcyc[$];
  logic [3:0]  gorder[$];
  logic [3:0]  prev_g;
  int          n_last, n_abort, abort_cyc;
  logic [15:0] last_data;

  frame_log_arbiter #(.WIDTH(16), .LENGTH(64), .N_SRC(4), .TIMEOUT(255)) dut (
    .clk        (clk),
    .rst        (rst),
    .src_req    (src_req),
    .src_data   (src_data),
    .src_valid  (src_valid),
    .src_grant  (src_grant),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_src_id (out_src_id),
    .out_last   (out_last),
    .out_abort  (out_abort),
    .frame_cnt  (frame_cnt),
    .drop_cnt   (drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Output monitor, sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (out_valid) begin
        wdata.push_back(out_data);
        wid.push_back(out_src_id);
        wcyc.push_back(cyc);
      end
      if (out_last) begin
        n_last++;
        last_data = out_data;
      end
      if (out_abort) begin
        n_abort++;
        abort_cyc = cyc;
      end
      if (src_grant != 4'b0 && prev_g == 4'b0) gorder.push_back(src_grant);
      prev_g = src_grant;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic mon_clear();
    wdata.delete();
    wid.delete();
    wcyc.delete();
    gorder.delete();
    prev_g    = 4'b0;
    n_last    = 0;
    n_abort   = 0;
    abort_cyc = 0;
    last_data = 16'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    src_req   = 4'b0;
    src_valid = 4'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mon_clear();
  endtask

  task automatic wait_grant(input string tag, input logic [3:0] exp);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (src_grant == 4'b0 && n < 50);
    chk(tag, src_grant, exp);
  endtask

  int n;
  int c0, c1, c2, c3;

  initial begin
    rst       = 1'b1;
    src_req   = 4'b0;
    src_valid = 4'b0;
    src_data  = '0;
    mon_clear();
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_grant", src_grant, 4'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_last", out_last, 1'b0);
    chk("rst_abort", out_abort, 1'b0);
    chk("rst_data", out_data, 16'h0);
    chk("rst_frames", frame_cnt, 32'd0);
    chk("rst_drops", drop_cnt, 16'd0);
    rst = 1'b0;
    mon_clear();

    // Single source, values 0..63
    src_req = 4'b0001;
    wait_grant("t1_grant", 4'b0001);
    src_req = 4'b0;
    for (int k = 0; k < 64; k++) begin
      src_valid   = 4'b0001;
      src_data[0] = 16'(k);
      @(negedge clk);
    end
    src_valid = 4'b0;
    repeat (4) @(negedge clk);
    chk("t1_words", wdata.size(), 64);
    for (int i = 0; i < wdata.size(); i++) chk("t1_word", {wid[i], wdata[i]}, {2'd0, 16'(i)});
    chk("t1_nlast", n_last, 1);
    chk("t1_lastdata", last_data, 16'd63);
    chk("t1_frames", frame_cnt, 32'd1);
    chk("t1_grant_idle", src_grant, 4'b0);

    // Round robin over three frames
    do_reset();
    src_req = 4'b1111;
    n = 0;
    while (n < 1000) begin
      @(negedge clk);
      n++;
      src_valid = src_grant;
      for (int i = 0; i < 4; i++) src_data[i] = 16'(i * 1000 + n);
      if (frame_cnt == 32'd3) break;
    end
    src_req   = 4'b0;
    src_valid = 4'b0;
    repeat (4) @(negedge clk);
    chk("t2_frames", frame_cnt, 32'd3);
    chk("t2_norder", gorder.size(), 3);
    chk("t2_order0", gorder.size() > 0 ? gorder[0] : 4'hx, 4'b0001);
    chk("t2_order1", gorder.size() > 1 ? gorder[1] : 4'hx, 4'b0010);
    chk("t2_order2", gorder.size() > 2 ? gorder[2] : 4'hx, 4'b0100);
    c0 = 0; c1 = 0; c2 = 0; c3 = 0;
    foreach (wid[i]) begin
      if (wid[i] == 2'd0) c0++;
      if (wid[i] == 2'd1) c1++;
      if (wid[i] == 2'd2) c2++;
      if (wid[i] == 2'd3) c3++;
    end
    chk("t2_ids", {c0[7:0], c1[7:0], c2[7:0], c3[7:0]}, {8'd64, 8'd64, 8'd64, 8'd0});
    chk("t2_nlast", n_last, 3);
    chk("t2_drops", drop_cnt, 16'd0);

    // Drops from source 2 while source 0 holds the grant; negative samples
    do_reset();
    src_req = 4'b0001;
    wait_grant("t3_grant", 4'b0001);
    src_req = 4'b0;
    for (int k = 0; k < 64; k++) begin
      src_valid   = 4'b0001 | ((k < 10 && k % 2 == 0) ? 4'b0100 : 4'b0000);
      src_data[0] = 16'(-(k + 1));
      src_data[2] = 16'h5555;
      @(negedge clk);
    end
    src_valid = 4'b0;
    repeat (4) @(negedge clk);
    chk("t3_drops", drop_cnt, 16'd5);
    chk("t3_words", wdata.size(), 64);
    c2 = 0;
    foreach (wid[i]) if (wid[i] == 2'd2) c2++;
    chk("t3_id2", c2, 0);
    chk("t3_first", wdata.size() > 0 ? wdata[0] : 16'hx, 16'hFFFF);
    chk("t3_lastdata", last_data, 16'hFFC0);

    // Idle timeout after ten words from source 1
    do_reset();
    src_req = 4'b0010;
    wait_grant("t4_grant", 4'b0010);
    src_req = 4'b0110;
    for (int k = 0; k < 10; k++) begin
      src_valid   = 4'b0010;
      src_data[1] = 16'(k + 7);
      @(negedge clk);
    end
    src_valid = 4'b0;
    @(negedge clk);
    chk("t4_grant_held", src_grant, 4'b0010);
    n = 0;
    while (n_abort == 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("t4_words", wdata.size(), 10);
    chk("t4_delay", wcyc.size() == 10 ? abort_cyc - wcyc[9] : -1, 255);
    chk("t4_frames", frame_cnt, 32'd0);
    chk("t4_nlast", n_last, 0);
    wait_grant("t4_next_grant", 4'b0100);
    chk("t4_abort_pulse", out_abort, 1'b0);
    chk("t4_nabort", n_abort, 1);
    src_req = 4'b0;

    // Reset mid-frame after word 30
    do_reset();
    src_req = 4'b0010;
    wait_grant("t5_grant", 4'b0010);
    src_req = 4'b0;
    for (int k = 0; k <= 30; k++) begin
      src_valid   = 4'b0010;
      src_data[1] = 16'(k);
      @(negedge clk);
    end
    src_valid = 4'b0;
    chk("t5_pre", {out_valid, out_src_id, out_data}, {1'b1, 2'd1, 16'd30});
    #1 rst = 1'b1;
    #1;
    chk("t5_grant0", src_grant, 4'b0);
    chk("t5_out0", {out_valid, out_last, out_abort, out_src_id, out_data}, 21'd0);
    chk("t5_cnt0", {frame_cnt, drop_cnt}, 48'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("t5_no_end", {n_last[7:0], n_abort[7:0]}, 16'd0);
    mon_clear();
    src_req = 4'b1111;
    wait_grant("t5_restart", 4'b0001);
    src_req = 4'b0;
    for (int k = 0; k < 64; k++) begin
      src_valid   = 4'b0001;
      src_data[0] = 16'(200 + k);
      @(negedge clk);
    end
    src_valid = 4'b0;
    repeat (4) @(negedge clk);
    chk("t5_words", wdata.size(), 64);
    chk("t5_first", wdata.size() > 0 ? wdata[0] : 16'hx, 16'd200);
    chk("t5_lastdata", last_data, 16'd263);
    chk("t5_frames", frame_cnt, 32'd1);

    // Drop counter saturation: 4 strobes per cycle with nobody granted
    do_reset();
    src_valid = 4'b1111;
    repeat (16383) @(negedge clk);
    chk("t6_below", drop_cnt, 16'hFFFC);
    @(negedge clk);
    chk("t6_sat", drop_cnt, 16'hFFFF);
    repeat (1116) @(negedge clk);
    chk("t6_hold", drop_cnt, 16'hFFFF);
    chk("t6_idle", {src_grant, out_valid}, 5'd0);
    src_valid = 4'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_log_arbiter.md
FRAME_LOG_ARBITER -- requirements
Module: frame_log_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 16, sample width in bits (signed).
REQ-002 SHALL have parameter LENGTH, default 64, words per frame.
REQ-003 SHALL have parameter N_SRC, default 4, number of requesting sources.
REQ-004 SHALL have parameter TIMEOUT, default 255, maximum idle cycles allowed inside a frame.
REQ-005 SHALL have port clk, input, 1 bit; the single clock, rising edge.
REQ-006 SHALL have port rst, input, 1 bit; one clock; reset is asynchronous and active-high.
REQ-007 SHALL have port src_req, input, N_SRC bits; per-source frame request, level.
REQ-008 SHALL have port src_data, input, N_SRC x WIDTH bits (signed); per-source sample.
REQ-009 SHALL have port src_valid, input, N_SRC bits; per-source sample strobe.
REQ-010 SHALL have port src_grant, output, N_SRC bits; one-hot grant, all zero when idle.
REQ-011 SHALL have port out_data, output, WIDTH bits (signed); forwarded sample to the logger sink.
REQ-012 SHALL have port out_valid, output, 1 bit; out_data qualifier.
REQ-013 SHALL have port out_src_id, output, clog2(N_SRC) bits; source index of out_data.
REQ-014 SHALL have port out_last, output, 1 bit; high with the final word of a frame.
REQ-015 SHALL have port out_abort, output, 1 bit; one-cycle pulse when a frame is abandoned.
REQ-016 SHALL have port frame_cnt, output, 32 bits; number of completed frames, wraps.
REQ-017 SHALL have port drop_cnt, output, 16 bits; number of dropped samples, saturating.

Function
REQ-018 SHALL implement an FSM with states IDLE and XFER.
REQ-019 SHALL, in IDLE with any src_req high, grant the first requester at or after (last_grant+1) mod N_SRC, enter XFER, and assert src_grant from the next cycle.
REQ-020 SHALL start last_grant at N_SRC-1 after reset, so that source 0 wins first.
REQ-021 SHALL hold the grant for the whole frame; src_req changes during XFER are ignored.
REQ-022 SHALL, in XFER, forward each valid sample from the granted source to out_data/out_valid/out_src_id with exactly 1 cycle registered latency.
REQ-023 SHALL count accepted words 0..LENGTH-1 and emit exactly LENGTH words per frame; out_last accompanies word LENGTH-1.
REQ-024 SHALL, after word LENGTH-1 is accepted, increment frame_cnt, update last_grant, and return to IDLE (grants remain zero for at least 1 cycle between frames).
REQ-025 SHALL count a source's src_valid as dropped when that source is not currently granted, and increment drop_cnt by popcount of such strobes in the cycle, saturating at 0xFFFF.
REQ-026 SHALL maintain an idle counter in XFER that resets on every accepted word; when it reaches TIMEOUT, it SHALL pulse out_abort, leave frame_cnt unchanged, update last_grant, and return to IDLE.
REQ-027 SHALL hold out_valid, out_last, and out_abort low whenever no qualifying event occurs; out_data holds its last value.

Reset
REQ-028 SHALL, on asserted rst, immediately clear state to IDLE and set src_grant, out_valid, out_last, out_abort, out_data, out_src_id, frame_cnt, drop_cnt, and all internal counters to 0.
REQ-029 SHALL discard a partially transferred frame on reset mid-frame, with no out_last and no out_abort.

Structure
REQ-030 SHALL place the FSM state enum and the counter widths in package lstm_log_pkg.
REQ-031 SHALL implement the round-robin pick as sub-module rr_pick (inputs req and last; outputs one-hot grant and index).

Verification
REQ-032 SHALL verify a single source: src_req=0001 with 64 consecutive valids of values 0..63 -> out_data 0..63 with src_id 0, out_last on value 63, and frame_cnt=1.
REQ-033 SHALL verify round robin: all four sources requesting continuously for 3 frames -> grant order 0,1,2 and frame_cnt=3.
REQ-034 SHALL verify drops: source 2 strobing 5 times while source 0 is granted -> drop_cnt=5 and no output words tagged 2.
REQ-035 SHALL verify timeout: source 1 sends 10 words then stops -> out_abort pulses 255 cycles after word 10, frame_cnt unchanged, and the next grant goes to source 2.
REQ-036 SHALL verify reset mid-frame: rst asserted after word 30 -> all outputs 0 at once, and the next frame restarts at source 0 with word count 0.
REQ-037 SHALL verify saturation: 70000 non-granted strobes -> drop_cnt holds 0xFFFF.
